avl_pio_ext: RTL and testbench
==============================

AVL_PIO_EXT -- requirements
Module: avl_pio_ext

Interface
REQ-001 Parameter WIDTH, default 8: number of PIO bits, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: reset value of the output data register, WIDTH bits.
REQ-003 Parameter EDGE_TYPE, default 0: edge that sets a capture bit; 0=rising, 1=falling, 2=any.
REQ-004 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-005 Port clk, in, 1: sole clock; every register updates on its rising edge.
REQ-006 Port reset, in, 1: synchronous, active-high reset.
REQ-007 Port address, in, 3: Avalon-MM word address.
REQ-008 Port chipselect, in, 1: slave select.
REQ-009 Port write_n, in, 1: active-low write strobe.
REQ-010 Port read_n, in, 1: active-low read strobe.
REQ-011 Port writedata, in, 32: write data.
REQ-012 Port readdata, out, 32: registered read data.
REQ-013 Port in_port, in, WIDTH: asynchronous pin inputs.
REQ-014 Port out_port, out, WIDTH: output data register.
REQ-015 Port oe_port, out, WIDTH: per-bit output enable, equal to DIRECTION.
REQ-016 Port irq, out, 1: active-high level interrupt.

Function
REQ-017 Register map: 0 DATA, 1 DIRECTION, 2 IRQ_MASK, 3 EDGE_CAPTURE, 4 OUTSET, 5 OUTCLEAR; addresses 6-7 read 0 and ignore writes.
REQ-018 A write is chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-019 DATA write loads out_port; DATA read returns out_port for bits with DIRECTION=1 and the synchronised input for bits with DIRECTION=0.
REQ-020 OUTSET write ORs writedata into out_port; OUTCLEAR write clears the out_port bits set in writedata; both addresses read 0.
REQ-021 DIRECTION and IRQ_MASK are plain read/write registers.
REQ-022 in_port passes through a SYNC_STAGES flip-flop chain, followed by one previous-value register; edges are detected between the last sync stage and that register.
REQ-023 Edge-to-capture latency: an in_port change that is stable before a clk edge sets its EDGE_CAPTURE bit exactly SYNC_STAGES+1 cycles later.
REQ-024 EDGE_CAPTURE bits are sticky; writing 1 clears a bit, writing 0 has no effect.
REQ-025 If a clear-write and a new edge hit the same bit in the same cycle, the bit stays set.
REQ-026 Edge detection runs for all bits regardless of DIRECTION.
REQ-027 irq = OR of (EDGE_CAPTURE AND IRQ_MASK), driven combinationally from registers; it deasserts in the cycle after the clearing write.
REQ-028 Read (chipselect=1, read_n=0) latches the addressed value into readdata one cycle later; readdata holds until the next read.
REQ-029 readdata bits [31:WIDTH] are always 0.
REQ-030 Simultaneous read_n=0 and write_n=0 performs both; readdata returns the pre-write value.

Reset
REQ-031 When reset=1 at a clk edge: out_port=RESET_VALUE, DIRECTION=0, IRQ_MASK=0, EDGE_CAPTURE=0, sync chain=0, previous-value register=0, readdata=0; hence oe_port=0 and irq=0.
REQ-032 An arm counter suppresses edge capture for the first SYNC_STAGES+1 cycles after reset deasserts, so a pin already high at reset exit is not captured.
REQ-033 Reset asserted mid-operation overrides any same-cycle bus write and restarts the arm counter.

Structure
REQ-034 Package avl_pio_pkg holds the register address constants and the EDGE_TYPE encodings.
REQ-035 The synchroniser is sub-module pio_sync, parameterised by width and depth, with a synchronous reset to 0.
REQ-036 Implementation target is 150-300 lines of RTL, with no latches and no clocks other than clk.

Verification
REQ-037 Reset, then read all six addresses -> DATA=RESET_VALUE masked by DIRECTION=0, i.e. the synchronised input (0 with in_port=0); all other registers 0; readdata valid one cycle after each read.
REQ-038 WIDTH=8: write DATA=0xA5, OUTSET=0x0A, OUTCLEAR=0x81 -> out_port 0xA5, then 0xAF, then 0x2E.
REQ-039 EDGE_TYPE=0, IRQ_MASK=0x01, DIRECTION=0: raise in_port[0] -> EDGE_CAPTURE=0x01 and irq=1 exactly 3 cycles later; write EDGE_CAPTURE=0x01 -> irq=0 next cycle.
REQ-040 Issue a clear-write to EDGE_CAPTURE bit 0 in the same cycle a new rising edge reaches the detector -> bit stays 1 and irq stays 1.
REQ-041 Hold in_port=0xFF through reset and release reset -> EDGE_CAPTURE stays 0 and irq never asserts.
REQ-042 Assert read and write to DIRECTION in the same cycle with writedata=0x3C -> readdata returns the old value (0x00); a following read returns 0x3C.

Source files
------------

// File: rtl/avl_pio_pkg.sv
// ----------------------------------------------------------------------------
// avl_pio_pkg
// Shared constants for the Avalon-MM PIO block: register word addresses
// and the encodings accepted by the EDGE_TYPE parameter.
// ----------------------------------------------------------------------------
package avl_pio_pkg;

    // Register word addresses (3-bit Avalon-MM address)
    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION    = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

    // EDGE_TYPE encodings
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync.sv
// ----------------------------------------------------------------------------
// pio_sync
// Multi-flop synchroniser for asynchronous pin inputs, synchronous reset to 0.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, clears every stage
//   d     - asynchronous input bits
//   q     - synchronised output (last stage)
// ----------------------------------------------------------------------------
module pio_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/avl_pio_ext.sv
// ----------------------------------------------------------------------------
// avl_pio_ext
// Avalon-MM parallel I/O with output set/clear, per-bit direction, sticky
// edge capture and a masked level interrupt.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   address, chipselect,
//   write_n, read_n,
//   writedata, readdata      - Avalon-MM slave (readdata registered)
//   in_port                  - asynchronous pin inputs
//   out_port                 - output data register
//   oe_port                  - per-bit output enable (DIRECTION register)
//   irq                      - OR of EDGE_CAPTURE & IRQ_MASK
// ----------------------------------------------------------------------------
module avl_pio_ext
    import avl_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic             wr_en;
    logic             rd_en;
    logic             armed;
    logic [2:0]       arm_cnt;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] in_sync_p0;
    logic [WIDTH-1:0] in_prev_p1;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rd_val;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & ~read_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Stage p0: synchronised pin value
    pio_sync #(
        .WIDTH (WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (in_sync_p0)
    );

    // Stage p1: previous value, edges are the difference between p0 and p1
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALLING: edge_det = ~in_sync_p0 & in_prev_p1;
            EDGE_ANY:     edge_det = in_sync_p0 ^ in_prev_p1;
            default:      edge_det = in_sync_p0 & ~in_prev_p1;
        endcase
    end

    // The synchroniser and previous-value register both restart at 0, so a
    // pin already high at reset exit looks like a rising edge until the chain
    // has filled; the arm counter masks exactly that window.
    assign armed   = (arm_cnt == ARM_CYCLES);
    assign cap_clr = (wr_en && address == ADDR_EDGE_CAPTURE) ? wdata : '0;

    always_comb begin
        case (address)
            ADDR_DATA:         rd_val = (out_port & direction) | (in_sync_p0 & ~direction);
            ADDR_DIRECTION:    rd_val = direction;
            ADDR_IRQ_MASK:     rd_val = irq_mask;
            ADDR_EDGE_CAPTURE: rd_val = edge_cap;
            default:           rd_val = '0;
        endcase
        rd_word              = '0;
        rd_word[WIDTH-1:0]   = rd_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port   <= RESET_VALUE;
            direction  <= '0;
            irq_mask   <= '0;
            edge_cap   <= '0;
            in_prev_p1 <= '0;
            arm_cnt    <= '0;
            readdata   <= '0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_DATA:      out_port  <= wdata;
                    ADDR_DIRECTION: direction <= wdata;
                    ADDR_IRQ_MASK:  irq_mask  <= wdata;
                    ADDR_OUTSET:    out_port  <= out_port | wdata;
                    ADDR_OUTCLEAR:  out_port  <= out_port & ~wdata;
                    default: ;
                endcase
            end
            // A new edge wins over a same-cycle clear of the same bit.
            edge_cap   <= (edge_cap & ~cap_clr) | (armed ? edge_det : '0);
            in_prev_p1 <= in_sync_p0;
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
            // rd_word is built from pre-write register values.
            if (rd_en) begin
                readdata <= rd_word;
            end
        end
    end

    assign oe_port = direction;
    assign irq     = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_avl_pio_ext.sv
// ----------------------------------------------------------------------------
// tb_avl_pio_ext
// Directed bench for avl_pio_ext (WIDTH=8, RESET_VALUE=0, rising edges,
// two-stage synchroniser).
// ----------------------------------------------------------------------------
module tb_avl_pio_ext;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  in_port = 8'h00;
    logic [7:0]  out_port;
    logic [7:0]  oe_port;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    avl_pio_ext #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(posedge clk);
        #1;
        d          = readdata;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic [31:0] exp_rd [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        reset = 1'b1;
        idle(3);
        vectors++;
        if (out_port !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out_port: got %h expected %h", out_port, 8'h00);
        end
        vectors++;
        if (oe_port !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_oe_port: got %h expected %h", oe_port, 8'h00);
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        vectors++;
        if (readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            vectors++;
            if (rd !== exp_rd[a]) begin
                miscompares++;
                $display("FAIL reset_read_addr%0d: got %h expected %h", a, rd, exp_rd[a]);
            end
        end
    endtask

    task automatic test_set_clear;
        logic [31:0] rd;
        bus_write(3'd0, 32'hFFFF_FFA5);
        vectors++;
        if (out_port !== 8'hA5) begin
            miscompares++;
            $display("FAIL data_write: got %h expected %h", out_port, 8'hA5);
        end
        bus_write(3'd4, 32'h0000_000A);
        vectors++;
        if (out_port !== 8'hAF) begin
            miscompares++;
            $display("FAIL outset: got %h expected %h", out_port, 8'hAF);
        end
        bus_write(3'd5, 32'h0000_0081);
        vectors++;
        if (out_port !== 8'h2E) begin
            miscompares++;
            $display("FAIL outclear: got %h expected %h", out_port, 8'h2E);
        end
        bus_read(3'd4, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL outset_read: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_direction_mix;
        logic [31:0] rd;
        bus_write(3'd1, 32'h0000_000F);
        vectors++;
        if (oe_port !== 8'h0F) begin
            miscompares++;
            $display("FAIL oe_port: got %h expected %h", oe_port, 8'h0F);
        end
        in_port = 8'h50;
        idle(3);
        // out 0x2E on low nibble, pins 0x50 on high nibble
        bus_read(3'd0, rd);
        vectors++;
        if (rd !== 32'h0000_005E) begin
            miscompares++;
            $display("FAIL data_mixed_read: got %h expected %h", rd, 32'h5E);
        end
        in_port = 8'h00;
        idle(4);
        bus_write(3'd3, 32'h0000_00FF);
        bus_read(3'd3, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL cap_clear_all: got %h expected %h", rd, 32'h0);
        end
        bus_write(3'd1, 32'h0);
    endtask

    task automatic test_edge_irq;
        logic [31:0] rd;
        logic [2:0]  irq_seq;
        bus_write(3'd2, 32'h0000_0001);
        @(negedge clk);
        in_port[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            irq_seq[i] = irq;
        end
        vectors++;
        if (irq_seq !== 3'b100) begin
            miscompares++;
            $display("FAIL edge_latency: irq per cycle got %b expected %b", irq_seq, 3'b100);
        end
        bus_read(3'd3, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL edge_capture_read: got %h expected %h", rd, 32'h1);
        end
        bus_write(3'd3, 32'h0000_0001);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_clear_collision;
        logic [31:0] rd;
        in_port[0] = 1'b0;
        idle(4);
        bus_read(3'd3, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL falling_ignored: got %h expected %h", rd, 32'h0);
        end
        in_port[0] = 1'b1;
        idle(4);
        bus_write(3'd3, 32'h0);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL cap_write_zero: irq got %b expected 1", irq);
        end
        in_port[0] = 1'b0;
        idle(4);
        @(negedge clk);
        in_port[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        // This write lands on the edge that detects the new rising edge.
        bus_write(3'd3, 32'h0000_0001);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_irq: got %b expected 1", irq);
        end
        bus_read(3'd3, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL collision_cap: got %h expected %h", rd, 32'h1);
        end
        bus_write(3'd3, 32'h0000_0001);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL post_collision_clear: irq got %b expected 0", irq);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        @(negedge clk);
        chipselect = 1'b1;
        read_n     = 1'b0;
        write_n    = 1'b0;
        address    = 3'd1;
        writedata  = 32'h0000_003C;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        vectors++;
        if (readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rw_same_cycle_read: got %h expected %h", readdata, 32'h0);
        end
        vectors++;
        if (oe_port !== 8'h3C) begin
            miscompares++;
            $display("FAIL rw_same_cycle_write: got %h expected %h", oe_port, 8'h3C);
        end
        bus_read(3'd1, rd);
        vectors++;
        if (rd !== 32'h0000_003C) begin
            miscompares++;
            $display("FAIL rw_followup_read: got %h expected %h", rd, 32'h3C);
        end
    endtask

    task automatic test_reset_pin_high;
        logic [31:0] rd;
        logic        irq_seen;
        @(negedge clk);
        reset   = 1'b1;
        in_port = 8'hFF;
        idle(3);
        bus_write(3'd0, 32'h0000_0055);
        vectors++;
        if (out_port !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_overrides_write: got %h expected %h", out_port, 8'h00);
        end
        vectors++;
        if (readdata !== 32'h0 || oe_port !== 8'h00) begin
            miscompares++;
            $display("FAIL midrun_reset: readdata %h oe %h expected 0 and 0", readdata, oe_port);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        bus_write(3'd2, 32'h0000_00FF);
        irq_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            irq_seen = irq_seen | irq;
        end
        vectors++;
        if (irq_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL pin_high_at_reset_irq: got %b expected 0", irq_seen);
        end
        bus_read(3'd3, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL pin_high_at_reset_cap: got %h expected %h", rd, 32'h0);
        end
        in_port = 8'h00;
        idle(4);
        in_port = 8'h01;
        idle(4);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL rearmed_capture: irq got %b expected 1", irq);
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_direction_mix();
        test_edge_irq();
        test_clear_collision();
        test_back_to_back();
        test_reset_pin_high();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
